// File: rtl/count_sched_if.sv
// count_sched_if: requester A/B symbol streams and per-packet result channel.
// master = symbol sources / result consumer side, slave = count_sched.
interface count_sched_if #(
  parameter int unsigned CNT_W = 8
);
  logic             a_valid;
  logic [1:0]       a_num;
  logic             a_last;
  logic             a_ready;
  logic             b_valid;
  logic [1:0]       b_num;
  logic             b_last;
  logic             b_ready;
  logic             res_valid;
  logic             res_id;
  logic [CNT_W-1:0] res_cnt;
  logic             res_ready;

  modport master (
    output a_valid, a_num, a_last, b_valid, b_num, b_last, res_ready,
    input  a_ready, b_ready, res_valid, res_id, res_cnt
  );

  modport slave (
    input  a_valid, a_num, a_last, b_valid, b_num, b_last, res_ready,
    output a_ready, b_ready, res_valid, res_id, res_cnt
  );
endinterface

// File: rtl/count_sched.sv
// count_sched: two-requester scheduler around a 2-bit symbol sequence detector.
// Grants the detector to A or B per packet, counts D2->D3 matches (saturating)
// and returns one result record per packet over a valid/ready handshake.
// Build option: FIXED_PRIO_EN -- A always wins a simultaneous request and the
// round-robin pointer is removed; otherwise round-robin arbitration.
module count_sched #(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  count_sched_if.slave      bus,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REPORT} state_t;
  typedef enum logic [1:0] {D0, D1, D2, D3} det_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  det_t             det;
  logic             owner;
  logic [CNT_W-1:0] cnt;
`ifndef FIXED_PRIO_EN
  logic             rr_ptr;
`endif

  logic             grant_c;
  logic [1:0]       sym_c;
  logic             last_c;
  logic             accept_c;
  logic             match_c;
  det_t             det_next_c;
  logic [CNT_W-1:0] cnt_next_c;

  // Winner among requesters seen in IDLE; a lone requester always wins.
  always_comb begin
    grant_c = 1'b0;
`ifdef FIXED_PRIO_EN
    grant_c = !bus.a_valid;
`else
    if (bus.a_valid && bus.b_valid) grant_c = rr_ptr;
    else                            grant_c = !bus.a_valid;
`endif
  end

  // Owner's symbol stream and acceptance qualifier.
  always_comb begin
    sym_c    = owner ? bus.b_num  : bus.a_num;
    last_c   = owner ? bus.b_last : bus.a_last;
    accept_c = 1'b0;
    if (state == S_RUN)
      accept_c = owner ? (bus.b_valid && bus.b_ready) : (bus.a_valid && bus.a_ready);
  end

  // Detector step and saturating match count for the current symbol.
  always_comb begin
    det_next_c = det;
    unique case (det)
      D0: det_next_c = (sym_c == 2'd1) ? D1 : D0;
      D1: begin
        unique case (sym_c)
          2'd2:    det_next_c = D2;
          2'd3:    det_next_c = D0;
          default: det_next_c = D1;
        endcase
      end
      D2: begin
        unique case (sym_c)
          2'd1:    det_next_c = D1;
          2'd3:    det_next_c = D3;
          default: det_next_c = D2;
        endcase
      end
      D3: begin
        unique case (sym_c)
          2'd1:    det_next_c = D1;
          2'd3:    det_next_c = D3;
          default: det_next_c = D0;
        endcase
      end
      default: det_next_c = D0;
    endcase
    match_c    = (det == D2) && (sym_c == 2'd3);
    cnt_next_c = (match_c && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
  end

  // Controller FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      det           <= D0;
      owner         <= 1'b0;
      cnt           <= '0;
`ifndef FIXED_PRIO_EN
      rr_ptr        <= 1'b0;
`endif
      bus.a_ready   <= 1'b0;
      bus.b_ready   <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= 1'b0;
      bus.res_cnt   <= '0;
      busy          <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.a_valid || bus.b_valid) begin
            owner       <= grant_c;
            det         <= D0;
            cnt         <= '0;
            bus.a_ready <= !grant_c;
            bus.b_ready <= grant_c;
            busy        <= 1'b1;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept_c) begin
            det <= det_next_c;
            cnt <= cnt_next_c;
            if (last_c) begin
              bus.a_ready   <= 1'b0;
              bus.b_ready   <= 1'b0;
              bus.res_valid <= 1'b1;
              bus.res_id    <= owner;
              bus.res_cnt   <= cnt_next_c;
              state         <= S_REPORT;
            end
          end
        end
        S_REPORT: begin
          if (bus.res_valid && bus.res_ready) begin
            bus.res_valid <= 1'b0;
            busy          <= 1'b0;
`ifndef FIXED_PRIO_EN
            rr_ptr        <= !owner;
`endif
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/count_sched.md
# count_sched

Two-requester scheduler and context controller for the shared 2-bit symbol sequence detector. It owns one detector instance and grants it to requester A or B one packet at a time, with the detector cleared at each packet start. It counts pattern matches within the packet and returns a per-packet result record through a valid/ready handshake. It sits between the symbol sources and any consumer of match statistics.

## Interface

- CNT_W, default 8: width of the per-packet match counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A symbol valid.
- a_num  in  2  requester A symbol.
- a_last  in  1  marks the last symbol of A's packet.
- a_ready  out  1  A symbol accepted when a_valid && a_ready.
- b_valid, b_num[1:0], b_last, b_ready: same as the A signals, for requester B.
- res_valid  out  1  result record valid.
- res_id  out  1  owner of the reported packet (0 = A, 1 = B).
- res_cnt  out  CNT_W  match count of the reported packet.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.

## Operation

- Controller FSM has three states.
  - IDLE: no ready asserted. If any requester is valid, arbitrate, latch the owner, clear the detector to D0, clear the counter, then go to RUN.
  - RUN: only the owner's ready is high. Each accepted symbol steps the detector. Accepting a symbol with last set goes to REPORT.
  - REPORT: res_valid is high and both readies are low. When res_valid && res_ready, go to IDLE.
- Detector states D0–D3. Transitions per accepted symbol:
  - D0: 1 → D1, anything else → D0.
  - D1: 1 → D1, 2 → D2, 3 → D0, 0 → D1.
  - D2: 1 → D1, 2 → D2, 3 → D3, 0 → D2.
  - D3: 1 → D1, 3 → D3, 0 or 2 → D0.
- A match is the D2 → D3 transition only. Staying in D3 does not count.
- res_cnt saturates at 2^CNT_W − 1; it never wraps.
- Round-robin arbitration: a pointer marks the preferred requester. It is A after reset. After each REPORT handshake it moves to the requester that did not own the packet. A lone valid requester always wins.
- A one-symbol packet (last on the first symbol) is legal and reports the count after that single step.
- The owner deasserting valid mid-packet only stalls the packet. There is no timeout and no preemption.
- The non-owner's valid is ignored until the next IDLE.

## Timing

- Reset values:
  - a_ready = 0, b_ready = 0, res_valid = 0, res_id = 0, res_cnt = 0, busy = 0.
  - FSM = IDLE, detector = D0, round-robin pointer = A.
- Asserting rst_n low at any point aborts the packet in progress immediately. No result is produced for it.
- Arbitration takes 1 cycle. The owner's ready rises in the cycle after IDLE sees a valid request.
- Throughput in RUN is one symbol per cycle.
- res_valid rises in the cycle after the last symbol is accepted. res_cnt includes that last symbol.
- res_id and res_cnt stay stable while res_valid && !res_ready.
- The return to IDLE takes 1 cycle. With continuous valid and res_ready held high, an N-symbol packet occupies N + 2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration

- FIXED_PRIO_EN defined: A always wins when both requesters are valid in IDLE, and the round-robin pointer is removed.
- FIXED_PRIO_EN undefined: round-robin arbitration as described under Operation.
- All other behaviour is identical in both builds.

## Test plan

- A sends 1,2,3 (last on 3) → res_valid 1 cycle after the last symbol is accepted, res_id = 0, res_cnt = 1.
- A sends 1,2,2,0,3,3,1,2,3 → res_cnt = 2. Sends 1,3,2,3 → res_cnt = 0.
- From reset, A and B are both valid with back-to-back 3-symbol packets → grants alternate A, B, A, B, each packet taking 5 cycles. With FIXED_PRIO_EN defined → A, A, A.
- CNT_W = 2, packet of 1,2,3 repeated 4 times → res_cnt = 3 (saturated).
- res_ready held low for 5 cycles in REPORT → res_id and res_cnt stable, a_ready = b_ready = 0, then a single handshake and a return to IDLE.
- rst_n pulsed low after 2 symbols of a packet → all outputs return to reset values asynchronously, no res_valid for the aborted packet, and the next packet counts from D0.
